// File: rtl/clock_time_ctrl.sv
// Time-keeping and time-set controller: debounced mode/inc buttons drive a RUN/SET FSM over hh:mm:ss.
// Latency: raw button rise to press pulse is 2 + DEBOUNCE_CYCLES cycles; field/mode updates are visible one cycle after a tick or press.
// Backpressure: none; sec_tick and button presses are consumed in the cycle they appear.
module clock_time_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DB_W            = 18
) (
  input  logic       in_clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic [1:0] mode,
  output logic       blink
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Button index 0 = mode, 1 = inc.
  logic [1:0]      btn_raw;
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      acc_q, acc_d;
  logic [1:0]      valid_q, valid_d;
  logic [1:0]      press_q, press_d;
  logic [DB_W-1:0] cnt_q [2];
  logic [DB_W-1:0] cnt_d [2];

  state_t      state_q, state_d;
  logic [4:0]  hour_q, hour_d;
  logic [5:0]  min_q, min_d;
  logic [5:0]  sec_q, sec_d;
  logic        blink_q, blink_d;
  logic        mode_p, inc_p;

  assign btn_raw = {inc_btn, mode_btn};
  assign mode_p  = press_q[0];
  assign inc_p   = press_q[1];

  // Two-flop synchronizers for the asynchronous buttons.
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce and press detection. Until valid_q is set the accepted level just
  // tracks the synced level without emitting pulses, so a button still held
  // through reset is learned as "already pressed" instead of firing a press.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      acc_d[b]   = acc_q[b];
      valid_d[b] = valid_q[b];
      cnt_d[b]   = cnt_q[b];
      press_d[b] = 1'b0;
      if (!valid_q[b]) begin
        if ((sync2_q[b] != acc_q[b]) || (sync1_q[b] != sync2_q[b])) begin
          acc_d[b] = sync2_q[b];
          cnt_d[b] = '0;
        end else if (cnt_q[b] == DB_LAST) begin
          valid_d[b] = 1'b1;
          cnt_d[b]   = '0;
        end else begin
          cnt_d[b] = cnt_q[b] + 1'b1;
        end
      end else if (sync2_q[b] == acc_q[b]) begin
        cnt_d[b] = '0;
      end else if (cnt_q[b] == DB_LAST) begin
        acc_d[b]   = sync2_q[b];
        cnt_d[b]   = '0;
        press_d[b] = sync2_q[b];
      end else begin
        cnt_d[b] = cnt_q[b] + 1'b1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      valid_q <= '0;
      press_q <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      acc_q   <= acc_d;
      valid_q <= valid_d;
      press_q <= press_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  // Mode sequencing, time counting with full carry, field editing and blink.
  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    blink_d = blink_q;

    if (state_q == RUN) begin
      blink_d = 1'b0;
      if (sec_tick) begin
        if (sec_q == 6'd59) begin
          sec_d = 6'd0;
          if (min_q == 6'd59) begin
            min_d  = 6'd0;
            hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end
    end else begin
      // Time is frozen while editing; ticks only drive the blink phase.
      if (sec_tick) begin
        blink_d = ~blink_q;
      end
      // Mode press takes priority over a coincident inc press.
      if (inc_p && !mode_p) begin
        case (state_q)
          SET_HOUR: hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
          SET_MIN:  min_d  = (min_q  == 6'd59) ? 6'd0 : min_q  + 6'd1;
          SET_SEC:  sec_d  = (sec_q  == 6'd59) ? 6'd0 : sec_q  + 6'd1;
          default:  ;
        endcase
      end
    end

    if (mode_p) begin
      blink_d = 1'b0;
      case (state_q)
        RUN:      state_d = SET_HOUR;
        SET_HOUR: state_d = SET_MIN;
        SET_MIN:  state_d = SET_SEC;
        default:  state_d = RUN;
      endcase
    end
  end

  // FSM and time registers.
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      hour_q  <= 5'd0;
      min_q   <= 6'd0;
      sec_q   <= 6'd0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      blink_q <= blink_d;
    end
  end

  assign hour  = hour_q;
  assign min   = min_q;
  assign sec   = sec_q;
  assign mode  = state_q;
  assign blink = blink_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Bench for clock_time_ctrl with a short debounce window.
// Stimulus pushes expected display state into a queue; a negedge monitor pops and compares.
// No backpressure: the monitor consumes one expectation per cycle.
module tb_clock_time_ctrl;

  logic       in_clk   = 1'b0;
  logic       rst      = 1'b1;
  logic       sec_tick = 1'b0;
  logic       mode_btn = 1'b0;
  logic       inc_btn  = 1'b0;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic [1:0] mode;
  logic       blink;

  clock_time_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .DB_W(3)
  ) dut (
    .in_clk  (in_clk),
    .rst     (rst),
    .sec_tick(sec_tick),
    .mode_btn(mode_btn),
    .inc_btn (inc_btn),
    .hour    (hour),
    .min     (min),
    .sec     (sec),
    .mode    (mode),
    .blink   (blink)
  );

  always #5 in_clk = ~in_clk;

  typedef struct {
    string      name;
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic [1:0] md;
    logic       bl;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Monitor: compare the DUT display state against each queued expectation.
  always @(negedge in_clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if ({hour, min, sec, mode, blink} !== {e.h, e.m, e.s, e.md, e.bl}) begin
        bad++;
        $display("FAIL %s: got %0d:%0d:%0d mode=%0d blink=%0d, want %0d:%0d:%0d mode=%0d blink=%0d",
                 e.name, hour, min, sec, mode, blink, e.h, e.m, e.s, e.md, e.bl);
      end
    end
  end

  task automatic expect_st(input string n, input int h, input int m, input int s,
                           input int md, input int bl);
    exp_t e;
    e.name = n;
    e.h    = 5'(h);
    e.m    = 6'(m);
    e.s    = 6'(s);
    e.md   = 2'(md);
    e.bl   = 1'(bl);
    exp_q.push_back(e);
    @(negedge in_clk);
    #1;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge in_clk);
    #1;
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1 sec_tick = 1'b1;
    @(posedge in_clk);
    #1 sec_tick = 1'b0;
  endtask

  // Hold the selected buttons long enough to debounce, then release and let
  // the release debounce complete too.
  task automatic press(input bit m, input bit i);
    @(posedge in_clk);
    #1;
    mode_btn = m;
    inc_btn  = i;
    repeat (10) @(posedge in_clk);
    #1;
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    repeat (8) @(posedge in_clk);
    #1;
  endtask

  task automatic incs(input int n);
    repeat (n) press(1'b0, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    cyc(3);
    expect_st("reset", 0, 0, 0, 0, 0);
    @(posedge in_clk);
    #1 rst = 1'b0;
    cyc(10);

    tick();
    expect_st("tick1", 0, 0, 1, 0, 0);
    tick();
    tick();
    expect_st("tick3", 0, 0, 3, 0, 0);

    // Two-cycle glitch must not be accepted.
    @(posedge in_clk);
    #1 mode_btn = 1'b1;
    cyc(2);
    mode_btn = 1'b0;
    cyc(10);
    expect_st("glitch_ignored", 0, 0, 3, 0, 0);

    press(1'b1, 1'b0);
    expect_st("run_to_set_hour", 0, 0, 3, 1, 0);

    incs(23);
    expect_st("hour_23", 23, 0, 3, 1, 0);
    incs(1);
    expect_st("hour_wrap", 0, 0, 3, 1, 0);
    incs(23);
    expect_st("hour_23_again", 23, 0, 3, 1, 0);

    press(1'b1, 1'b0);
    expect_st("to_set_min", 23, 0, 3, 2, 0);
    incs(59);
    expect_st("min_59", 23, 59, 3, 2, 0);
    incs(1);
    expect_st("min_wrap_no_carry", 23, 0, 3, 2, 0);

    for (int k = 1; k <= 5; k++) begin
      tick();
      expect_st("set_min_tick_blink", 23, 0, 3, 2, k % 2);
    end

    incs(59);
    expect_st("min_59_again", 23, 59, 3, 2, 1);

    press(1'b1, 1'b0);
    expect_st("to_set_sec_blink_clr", 23, 59, 3, 3, 0);
    incs(55);
    expect_st("sec_58", 23, 59, 58, 3, 0);

    press(1'b1, 1'b0);
    expect_st("back_to_run", 23, 59, 58, 0, 0);
    tick();
    expect_st("run_235959", 23, 59, 59, 0, 0);
    tick();
    expect_st("rollover", 0, 0, 0, 0, 0);

    press(1'b0, 1'b1);
    expect_st("inc_in_run_ignored", 0, 0, 0, 0, 0);

    press(1'b1, 1'b0);
    expect_st("to_set_hour_2", 0, 0, 0, 1, 0);
    incs(5);
    expect_st("hour_5", 5, 0, 0, 1, 0);
    press(1'b1, 1'b1);
    expect_st("mode_beats_inc", 5, 0, 0, 2, 0);

    press(1'b1, 1'b0);
    expect_st("to_set_sec_2", 5, 0, 0, 3, 0);
    incs(30);
    expect_st("sec_30", 5, 0, 30, 3, 0);
    tick();
    expect_st("set_sec_tick_frozen", 5, 0, 30, 3, 1);

    // Reset in the middle of a mode-button debounce, button still held after.
    @(posedge in_clk);
    #1 mode_btn = 1'b1;
    cyc(3);
    rst = 1'b1;
    expect_st("rst_mid_edit", 0, 0, 0, 0, 0);
    cyc(2);
    rst = 1'b0;
    cyc(20);
    expect_st("no_stray_press", 0, 0, 0, 0, 0);
    mode_btn = 1'b0;
    cyc(10);
    expect_st("release_after_rst", 0, 0, 0, 0, 0);
    press(1'b1, 1'b0);
    expect_st("press_after_rst", 0, 0, 0, 1, 0);

    for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(negedge in_clk);
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
